// File: rtl/tsu_ts_queue_mc.sv
// -----------------------------------------------------------------------------
// tsu_ts_queue_mc
// Multi-channel timestamp queue. Each capture channel latches the RTC time and
// a per-frame info word on its strobe. A round-robin arbiter then merges the
// held events into one shared FIFO, and every entry is tagged with its channel.
//
// Optional feature (macro TSU_QUEUE_FWFT_EN):
//   defined   - first-word fall-through read: q_rd_data shows the head entry
//               and q_rd_vld = !q_empty.
//   undefined - registered read: q_rd_en pops the head into q_rd_data, and
//               q_rd_vld pulses for one cycle.
//
// Ports:
//   clk        RTC-domain clock
//   rst_n      asynchronous active-low reset
//   ts_in      free-running RTC time (TS_W)
//   cap_vld    per-channel capture strobe (NUM_CH)
//   cap_info   packed per-channel info, channel c at [c*INFO_W +: INFO_W]
//   q_clr      synchronous flush of FIFO, pending events, drop flags, rr pointer
//   q_rd_en    pop request
//   q_rd_data  entry {ch_id, info, ts}, ch_id in the MSBs
//   q_rd_vld   q_rd_data valid
//   q_rd_cnt   FIFO occupancy 0..DEPTH
//   q_empty    occupancy == 0
//   q_full     occupancy == DEPTH
//   ch_drop    sticky per-channel drop flags
//   q_ovf      sticky OR of ch_drop
// -----------------------------------------------------------------------------
module tsu_ts_queue_mc #(
  parameter int NUM_CH = 2,
  parameter int TS_W   = 32,
  parameter int INFO_W = 24,
  parameter int DEPTH  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = AW + 1,
  localparam int DATA_W = CH_W + INFO_W + TS_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TS_W-1:0]          ts_in,
  input  logic [NUM_CH-1:0]        cap_vld,
  input  logic [NUM_CH*INFO_W-1:0] cap_info,
  input  logic                     q_clr,
  input  logic                     q_rd_en,
  output logic [DATA_W-1:0]        q_rd_data,
  output logic                     q_rd_vld,
  output logic [CNT_W-1:0]         q_rd_cnt,
  output logic                     q_empty,
  output logic                     q_full,
  output logic [NUM_CH-1:0]        ch_drop,
  output logic                     q_ovf
);

  // Capture holding registers
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [TS_W-1:0]   ts_hold_q   [NUM_CH];
  logic [TS_W-1:0]   ts_hold_d   [NUM_CH];
  logic [INFO_W-1:0] info_hold_q [NUM_CH];
  logic [INFO_W-1:0] info_hold_d [NUM_CH];
  logic [NUM_CH-1:0] ch_drop_q, ch_drop_d;
  logic              ovf_q, ovf_d;

  // Arbiter
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              gnt_vld_s;
  logic [CH_W-1:0]   gnt_ch_s;

  // FIFO
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              pop_s;
  logic [DATA_W-1:0] wr_data_s;

  // Round-robin search from rr_q upward, wrapping modulo NUM_CH; no grant while full
  always_comb begin
    int  idx;
    logic take;
    gnt_vld_s = 1'b0;
    gnt_ch_s  = '0;
    idx       = 0;
    take      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx       = (int'(rr_q) + i) % NUM_CH;
      take      = !gnt_vld_s && pend_q[idx];
      gnt_ch_s  = take ? CH_W'(idx) : gnt_ch_s;
      gnt_vld_s = gnt_vld_s | take;
    end
    gnt_vld_s = gnt_vld_s & ~full_q;
  end

  // Next-state for capture holds, drop flags and rr pointer
  always_comb begin
    logic gnt_c;
    pend_d      = pend_q;
    ch_drop_d   = ch_drop_q;
    ts_hold_d   = ts_hold_q;
    info_hold_d = info_hold_q;
    gnt_c       = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      gnt_c = gnt_vld_s && (gnt_ch_s == CH_W'(c));
      if (cap_vld[c] && (!pend_q[c] || gnt_c)) begin
        // Slot is free (or being freed by this grant): take the new event
        pend_d[c]      = 1'b1;
        ts_hold_d[c]   = ts_in;
        info_hold_d[c] = cap_info[c*INFO_W +: INFO_W];
      end else if (cap_vld[c]) begin
        // Slot still occupied: keep the held event, flag the loss
        ch_drop_d[c] = 1'b1;
      end else if (gnt_c) begin
        pend_d[c] = 1'b0;
      end else begin
        pend_d[c] = pend_q[c];
      end
    end
    if (q_clr) begin
      pend_d    = '0;
      ch_drop_d = '0;
    end else begin
      pend_d    = pend_d;
    end
    ovf_d = |ch_drop_d;
    if (q_clr) begin
      rr_d = '0;
    end else if (gnt_vld_s) begin
      rr_d = CH_W'((int'(gnt_ch_s) + 1) % NUM_CH);
    end else begin
      rr_d = rr_q;
    end
  end

  assign wr_data_s = {gnt_ch_s, info_hold_q[gnt_ch_s], ts_hold_q[gnt_ch_s]};
  assign pop_s     = q_rd_en && !empty_q;

  // FIFO pointer, occupancy and flag next-state; flags are derived from the next pointers
  always_comb begin
    if (q_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, gnt_vld_s};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
      cnt_d    = cnt_q + {{AW{1'b0}}, gnt_vld_s} - {{AW{1'b0}}, pop_s};
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      ch_drop_q <= '0;
      ovf_q     <= 1'b0;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ts_hold_q[c]   <= '0;
        info_hold_q[c] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      ch_drop_q   <= ch_drop_d;
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ts_hold_q   <= ts_hold_d;
      info_hold_q <= info_hold_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (gnt_vld_s && !q_clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_s;
    end else begin
      mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
    end
  end

`ifdef TSU_QUEUE_FWFT_EN
  // Head entry is presented directly
  assign q_rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign q_rd_vld  = !empty_q;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  // Registered read port: data holds its last value when nothing is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else if (q_clr) begin
      rd_data_q <= rd_data_q;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= pop_s;
      if (pop_s) begin
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign q_rd_data = rd_data_q;
  assign q_rd_vld  = rd_vld_q;
`endif

  assign q_rd_cnt = cnt_q;
  assign q_empty  = empty_q;
  assign q_full   = full_q;
  assign ch_drop  = ch_drop_q;
  assign q_ovf    = ovf_q;

endmodule

// File: tb/tb_tsu_ts_queue_mc.sv
// Directed bench for tsu_ts_queue_mc (NUM_CH=2, TS_W=32, INFO_W=24, DEPTH=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tsu_ts_queue_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ts_in;
  logic [1:0]  cap_vld;
  logic [47:0] cap_info;
  logic        q_clr;
  logic        q_rd_en;
  logic [56:0] q_rd_data;
  logic        q_rd_vld;
  logic [4:0]  q_rd_cnt;
  logic        q_empty;
  logic        q_full;
  logic [1:0]  ch_drop;
  logic        q_ovf;

  int total = 0;
  int bad   = 0;
  int nxt   = 0;

  always #5 clk = ~clk;

  tsu_ts_queue_mc #(.NUM_CH(2), .TS_W(32), .INFO_W(24), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ts_in(ts_in), .cap_vld(cap_vld), .cap_info(cap_info),
    .q_clr(q_clr), .q_rd_en(q_rd_en), .q_rd_data(q_rd_data), .q_rd_vld(q_rd_vld),
    .q_rd_cnt(q_rd_cnt), .q_empty(q_empty), .q_full(q_full), .ch_drop(ch_drop), .q_ovf(q_ovf)
  );

  function automatic logic [56:0] ent(input logic ch, input logic [23:0] info, input logic [31:0] ts);
    return {ch, info, ts};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ts_in = 32'h0; cap_vld = 2'b00; cap_info = 48'h0; q_clr = 1'b0; q_rd_en = 1'b0;
    step(); step();
    chk("rst_empty", 64'(q_empty), 64'd1);
    chk("rst_full", 64'(q_full), 64'd0);
    chk("rst_cnt", 64'(q_rd_cnt), 64'd0);
    chk("rst_drop", 64'(ch_drop), 64'd0);
    chk("rst_ovf", 64'(q_ovf), 64'd0);
    rst_n = 1'b1;
    step();

`ifdef TSU_QUEUE_FWFT_EN
    chk("fwft_rst_vld", 64'(q_rd_vld), 64'd0);
    cap_vld = 2'b01; ts_in = 32'h100; cap_info = {24'h0, 24'hA1};
    step();
    cap_vld = 2'b00; ts_in = 32'h555;
    step();
    chk("fwft_vld", 64'(q_rd_vld), 64'd1);
    chk("fwft_data", 64'(q_rd_data), 64'(ent(1'b0, 24'hA1, 32'h100)));
    chk("fwft_cnt", 64'(q_rd_cnt), 64'd1);
    q_rd_en = 1'b1;
    step();
    q_rd_en = 1'b0;
    chk("fwft_pop_vld", 64'(q_rd_vld), 64'd0);
    chk("fwft_pop_empty", 64'(q_empty), 64'd1);
`else
    chk("rst_vld", 64'(q_rd_vld), 64'd0);
    chk("rst_data", 64'(q_rd_data), 64'd0);

    // Single capture: ts must be the value at the strobe edge, not the write edge
    cap_vld = 2'b01; ts_in = 32'h100; cap_info = {24'h0, 24'hA1};
    step();
    cap_vld = 2'b00; ts_in = 32'h555;
    chk("t1_cnt_k", 64'(q_rd_cnt), 64'd0);
    step();
    chk("t1_cnt_k1", 64'(q_rd_cnt), 64'd1);
    chk("t1_empty_k1", 64'(q_empty), 64'd0);
    q_rd_en = 1'b1;
    step();
    q_rd_en = 1'b0;
    chk("t1_pop_vld", 64'(q_rd_vld), 64'd1);
    chk("t1_pop_data", 64'(q_rd_data), 64'(ent(1'b0, 24'hA1, 32'h100)));
    chk("t1_empty", 64'(q_empty), 64'd1);
    step();
    chk("t1_vld_pulse", 64'(q_rd_vld), 64'd0);
    // Pop while empty is ignored
    q_rd_en = 1'b1;
    step();
    q_rd_en = 1'b0;
    chk("t1_emptypop_vld", 64'(q_rd_vld), 64'd0);
    chk("t1_emptypop_data", 64'(q_rd_data), 64'(ent(1'b0, 24'hA1, 32'h100)));

    // Flush on an empty queue brings rr back to 0
    q_clr = 1'b1;
    step();
    q_clr = 1'b0;

    // Both channels strobe together with rr=0: ch0 first, ch1 next cycle, same ts
    cap_vld = 2'b11; ts_in = 32'h200; cap_info = {24'hB1, 24'hB0};
    step();
    cap_vld = 2'b00; ts_in = 32'h999;
    step();
    chk("t2_cnt1", 64'(q_rd_cnt), 64'd1);
    step();
    chk("t2_cnt2", 64'(q_rd_cnt), 64'd2);
    q_rd_en = 1'b1;
    step();
    chk("t2_first", 64'(q_rd_data), 64'(ent(1'b0, 24'hB0, 32'h200)));
    step();
    q_rd_en = 1'b0;
    chk("t2_second", 64'(q_rd_data), 64'(ent(1'b1, 24'hB1, 32'h200)));
    chk("t2_empty", 64'(q_empty), 64'd1);

    // Fill 16 entries from ch0 without reading
    for (int i = 0; i < 16; i++) begin
      cap_vld = 2'b01; ts_in = 32'(32'h1000 + i); cap_info = {24'h0, 24'(i)};
      step();
    end
    cap_vld = 2'b00;
    step();
    chk("t3_full", 64'(q_full), 64'd1);
    chk("t3_cnt16", 64'(q_rd_cnt), 64'd16);
    // ch1: first strobe held, second dropped
    cap_vld = 2'b10; ts_in = 32'h3000; cap_info = {24'hC1, 24'h0};
    step();
    chk("t3_nodrop_yet", 64'(ch_drop), 64'd0);
    cap_vld = 2'b10; ts_in = 32'h3001; cap_info = {24'hC2, 24'h0};
    step();
    cap_vld = 2'b00;
    chk("t3_drop", 64'(ch_drop), 64'b10);
    chk("t3_ovf", 64'(q_ovf), 64'd1);
    chk("t3_full_hold", 64'(q_full), 64'd1);
    chk("t3_cnt_hold", 64'(q_rd_cnt), 64'd16);
    q_rd_en = 1'b1;
    step();
    q_rd_en = 1'b0;
    chk("t3_pop_data", 64'(q_rd_data), 64'(ent(1'b0, 24'h0, 32'h1000)));
    chk("t3_pop_cnt", 64'(q_rd_cnt), 64'd15);
    chk("t3_pop_notfull", 64'(q_full), 64'd0);
    step();
    chk("t3_refill_cnt", 64'(q_rd_cnt), 64'd16);
    chk("t3_refill_full", 64'(q_full), 64'd1);
    // Drain and check order; held ch1 entry is last
    q_rd_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      step();
      if (j < 15) begin
        chk("t3_drain", 64'(q_rd_data), 64'(ent(1'b0, 24'(j + 1), 32'(32'h1000 + j + 1))));
      end else begin
        chk("t3_drain_ch1", 64'(q_rd_data), 64'(ent(1'b1, 24'hC1, 32'h3000)));
      end
    end
    q_rd_en = 1'b0;
    step();
    chk("t3_drained", 64'(q_empty), 64'd1);

    // Streaming 40 entries with continuous reads: pointers wrap, order kept
    nxt = 0;
    q_rd_en = 1'b1;
    for (int i = 0; i < 46; i++) begin
      if (i < 40) begin
        cap_vld = 2'b01; ts_in = 32'(32'h5000 + i); cap_info = {24'h0, 24'(24'h50 + i)};
      end else begin
        cap_vld = 2'b00;
      end
      step();
      if (q_rd_vld) begin
        chk("t4_data", 64'(q_rd_data), 64'(ent(1'b0, 24'(24'h50 + nxt), 32'(32'h5000 + nxt))));
        nxt++;
      end
      chk("t4_cnt_bound", 64'(q_rd_cnt <= 5'd16), 64'd1);
    end
    q_rd_en = 1'b0;
    chk("t4_count", 64'(nxt), 64'd40);
    chk("t4_empty", 64'(q_empty), 64'd1);

    // Flush with 5 entries and ch0 pending; a capture in the flush cycle is lost
    for (int i = 0; i < 6; i++) begin
      cap_vld = 2'b01; ts_in = 32'(32'h7000 + i); cap_info = 48'h0;
      step();
    end
    chk("t5_cnt5", 64'(q_rd_cnt), 64'd5);
    chk("t5_drop_pre", 64'(ch_drop), 64'b10);
    q_clr = 1'b1; cap_vld = 2'b11;
    step();
    q_clr = 1'b0; cap_vld = 2'b00;
    chk("t5_cnt0", 64'(q_rd_cnt), 64'd0);
    chk("t5_empty", 64'(q_empty), 64'd1);
    chk("t5_drop", 64'(ch_drop), 64'd0);
    chk("t5_ovf", 64'(q_ovf), 64'd0);
    chk("t5_vld", 64'(q_rd_vld), 64'd0);
    step(); step(); step();
    chk("t5_no_late_entry", 64'(q_rd_cnt), 64'd0);
    q_rd_en = 1'b1;
    step();
    q_rd_en = 1'b0;
    chk("t5_emptypop_vld", 64'(q_rd_vld), 64'd0);
    chk("t5_data_held", 64'(q_rd_data), 64'(ent(1'b0, 24'h77, 32'h5027)));

    // Asynchronous reset mid-operation
    cap_vld = 2'b01; ts_in = 32'h8000;
    step();
    cap_vld = 2'b10;
    step();
    cap_vld = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", 64'(q_rd_cnt), 64'd0);
    chk("t6_rst_empty", 64'(q_empty), 64'd1);
    chk("t6_rst_data", 64'(q_rd_data), 64'd0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("t6_no_entry", 64'(q_rd_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
